// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if
// Purpose: bundles the decoder-side request and the sequencer-side status
//          and result of a MULT/MULTU instruction into one port.
// Signals:
//   start      decoder asserts while the current instruction is MULT/MULTU
//   is_signed  1 = MULT (two's complement), 0 = MULTU
//   opA, opB   multiplicand / multiplier, bit 0 is the MSB
//   stall      holds PC and suppresses register write while high
//   busy       high while the sequencer is iterating
//   done       one-cycle pulse when the product has just been loaded
//   product    registered 64-bit result, bits [32:63] are the low word
// Modports:
//   master     the decoder / datapath side
//   slave      the multiply sequencer
`timescale 1ns/1ps
interface mult_sequencer_if;
    logic        start;
    logic        is_signed;
    logic [0:31] opA;
    logic [0:31] opB;
    logic        stall;
    logic        busy;
    logic        done;
    logic [0:63] product;

    modport master (
        output start, is_signed, opA, opB,
        input  stall, busy, done, product
    );

    modport slave (
        input  start, is_signed, opA, opB,
        output stall, busy, done, product
    );
endinterface

// File: rtl/mult_sequencer.sv
// mult_sequencer
// Purpose: multi-cycle shift-and-add multiplier for MULT/MULTU. Operands are
//          converted to magnitudes on capture, multiplied unsigned over up to
//          32 iterations, and the sign is applied once when the product is
//          loaded.
// Ports:
//   clock  sole clock, rising edge
//   reset  asynchronous active-high reset, clears all state
//   bus    mult_sequencer_if.slave (start/is_signed/opA/opB in,
//          stall/busy/done/product out)
// Configuration:
//   MULT_EARLY_EXIT_EN  when defined, iteration stops after the first cycle
//                       whose shifted multiplier is zero; the product is the
//                       same either way, only the latency changes.
`timescale 1ns/1ps
module mult_sequencer (
    input  logic             clock,
    input  logic             reset,
    mult_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc;
    logic [5:0]  count;
    logic        neg;
    logic [63:0] product_q;
    logic        busy_q;
    logic        done_q;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] acc_next;
    logic [31:0] mplier_next;
    logic        last_step;

    // Magnitudes of the incoming operands and the next iteration's values.
    // Negating 0x80000000 in 32 bits yields 0x80000000, which read as
    // unsigned is exactly 2^31, so the most negative input needs no
    // special case.
    always_comb begin
        mag_a       = (bus.is_signed && bus.opA[0]) ? (~bus.opA + 32'd1) : bus.opA;
        mag_b       = (bus.is_signed && bus.opB[0]) ? (~bus.opB + 32'd1) : bus.opB;
        acc_next    = mplier[0] ? (acc + mcand) : acc;
        mplier_next = mplier >> 1;
`ifdef MULT_EARLY_EXIT_EN
        last_step   = (count == 6'd31) || (mplier_next == 32'd0);
`else
        last_step   = (count == 6'd31);
`endif
    end

    // Stall must already be high in the cycle start is first seen so the
    // instruction does not retire, and must drop in DONE so it does.
    assign bus.stall   = !reset && (((state == IDLE) && bus.start) || (state == RUN));
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

    // Sequencer: capture in IDLE, one add/shift per RUN cycle, load the
    // signed product on the edge into DONE, then always return to IDLE so a
    // following instruction can be captured one cycle later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
            neg       <= 1'b0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mcand  <= {32'd0, mag_a};
                        mplier <= mag_b;
                        neg    <= bus.is_signed && (bus.opA[0] ^ bus.opB[0]);
                        acc    <= '0;
                        count  <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier_next;
                    count  <= count + 6'd1;
                    if (last_step) begin
                        product_q <= neg ? (~acc_next + 64'd1) : acc_next;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer
// Purpose: self-checking bench for mult_sequencer. Expected products come
//          from plain 64-bit arithmetic and expected latencies from the
//          position of the multiplier's highest set bit.
`timescale 1ns/1ps
module tb_mult_sequencer;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [63:0] lastProduct = 64'd0;

`ifdef MULT_EARLY_EXIT_EN
    localparam bit earlyExit = 1'b1;
`else
    localparam bit earlyExit = 1'b0;
`endif

    mult_sequencer_if bus ();

    mult_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, actual, expected);
        end
    endtask

    // Reference product: the true mathematical product, truncated to 64 bits.
    function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Number of iteration cycles: 32 normally, or the bit length of |b|
    // (at least 1) when early exit is built in.
    function automatic int refRunLength(input logic [31:0] b, input logic s);
        logic [31:0] m;
        int n;
        m = (s && b[31]) ? (32'd0 - b) : b;
        n = 1;
        for (int i = 0; i < 32; i++)
            if (m[i]) n = i + 1;
        return earlyExit ? n : 32;
    endfunction

    // Issues one instruction starting at a falling edge with the sequencer
    // in IDLE, follows it through to DONE, then leaves start high with junk
    // operands into the next IDLE cycle (start in DONE must be ignored).
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
        int runCycles;
        logic [63:0] want;
        want = refProduct(a, b, s);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.opA       = a;
        bus.opB       = b;
        #1;
        checkOutput("stall_idle_start", bus.stall, 1);
        checkOutput("product_held_idle", bus.product, lastProduct);
        @(posedge clock);
        @(negedge clock);
        runCycles = 0;
        while (bus.busy && runCycles < 100) begin
            bus.start     = 1'($urandom_range(0, 1));
            bus.is_signed = 1'($urandom_range(0, 1));
            bus.opA       = $urandom;
            bus.opB       = $urandom;
            #1;
            checkOutput("stall_run", bus.stall, 1);
            checkOutput("product_held_run", bus.product, lastProduct);
            runCycles++;
            @(negedge clock);
        end
        checkOutput("run_length", runCycles, refRunLength(b, s));
        checkOutput("done_pulse", bus.done, 1);
        checkOutput("product", bus.product, want);
        bus.start = 1'b1;
        bus.opA   = $urandom;
        bus.opB   = $urandom;
        #1;
        checkOutput("stall_done", bus.stall, 0);
        lastProduct = want;
        @(negedge clock);
        checkOutput("done_one_cycle", bus.done, 0);
        checkOutput("idle_after_done", bus.busy, 0);
        checkOutput("product_kept", bus.product, want);
    endtask

    // Main sequence: reset behaviour, abort mid-run, directed vectors
    // back to back, then randomized back-to-back instructions.
    initial begin
        int doneSeen;
        logic [31:0] ra;
        logic [31:0] rb;
        reset         = 1'b1;
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.opA       = 32'd7;
        bus.opB       = 32'd6;
        repeat (2) @(negedge clock);
        checkOutput("reset_stall", bus.stall, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_product", bus.product, 64'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clock);

        // Abort at RUN cycle 10: no DONE pulse, product untouched.
        bus.start = 1'b1;
        bus.opA   = 32'd3;
        bus.opB   = 32'd5;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (9) @(negedge clock);
        checkOutput("busy_before_abort", bus.busy, 1);
        reset     = 1'b1;
        bus.start = 1'b1;
        #1;
        checkOutput("abort_stall", bus.stall, 0);
        checkOutput("abort_busy", bus.busy, 0);
        @(negedge clock);
        reset     = 1'b0;
        bus.start = 1'b0;
        doneSeen  = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done) doneSeen++;
        end
        checkOutput("abort_no_done", doneSeen, 0);
        checkOutput("abort_product", bus.product, 64'd0);

        applyStimulus(32'd7, 32'd6, 1'b0);
        applyStimulus(32'hFFFFFFFD, 32'd5, 1'b1);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        applyStimulus(32'h80000000, 32'h80000000, 1'b1);
        applyStimulus(32'd9, 32'd1, 1'b0);
        applyStimulus(32'h12345678, 32'd0, 1'b1);
        applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b1);

        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 2) == 0) ra = ra >> $urandom_range(0, 31);
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)));
        end
        bus.start = 1'b0;
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
